reg_alu_pipe_datapath: RTL and testbench
========================================

// Module: reg_alu_pipe_datapath
// PURPOSE
//  Parametrised successor of the single-cycle register/ALU datapath: register file + ALU + status register,
//  split into EX and WB stages with result forwarding and a valid qualifier per issued control word.
//  Sits between the control unit (sources da/sa/sb/fs/k each cycle) and the memory/PC buses (consume data).
// PARAMETERS
//  DATA_W     64  datapath and register width (>=8, power of 2)
//  REG_COUNT  32  registers (power of 2); index REG_COUNT-1 is the zero register
//  ADDR_W     $clog2(REG_COUNT)  register index width (derived, not overridden)
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high
//  issue_valid  in   1       control word below is live this cycle; low = bubble
//  da           in   ADDR_W  destination register
//  sa           in   ADDR_W  operand A register
//  sb           in   ADDR_W  operand B register
//  fs           in   5       function select (see BEHAVIOUR)
//  sel_b        in   1       1: operand B = k, 0: operand B = R[sb]
//  reg_write    in   1       write result to R[da] in WB
//  status_load  in   1       load V,C,N,Z from this op
//  k            in   DATA_W  constant operand
//  data         out  DATA_W  registered ALU result (EX/WB stage)
//  data_valid   out  1       data holds a result issued the previous cycle
//  status       out  4       {V,C,N,Z} registered flags
// BEHAVIOUR
//  - Reset (async): all registers, data, data_valid, status, WB pipeline cleared to 0; in-flight write dropped.
//  - Edge n with issue_valid=1: ALU result -> data, data_valid=1, WB reg captures {da,reg_write}. issue_valid=0 -> data_valid=0, data holds.
//  - Edge n+1: if WB valid & reg_write & da!=REG_COUNT-1, R[da] <= WB result. Writes to zero reg discarded; reads return 0.
//  - Latency: 1 cycle to data; 2 cycles to register file. Issue every cycle, no stalls.
//  - fs[4:2] op: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SHL, 101 SHR (logical), 110 ASR, 111 PASS B.
//    fs[1] inverts A, fs[0] inverts B and is carry-in to ADD (A-B = 01001). Shift amount = B[$clog2(DATA_W)-1:0], A is shifted.
//  - Flags: Z = result==0, N = result[DATA_W-1]; C = carry-out, V = signed overflow for ADD; C=V=0 for all other ops.
//  - status updated only when issue_valid & status_load; otherwise holds.
//  - Operand read order: zero reg -> 0; else forwarded WB result if WB valid & reg_write & WB da==sa/sb (per operand); else R[sa]/R[sb].
//  - Back-to-back same da: later write wins; forwarding always selects youngest (WB) value.
// CONFIGURATION
//  REG_ALU_FORWARD_EN defined: forwarding as above, dependent op may issue the cycle after its producer.
//  Not defined: operands come from register file only; reading a register written by the immediately
//  preceding op returns the stale value; control unit must insert one bubble. All else identical.
// STRUCTURE
//  Package datapath_pkg: FS op localparams (FS_AND..FS_PASSB), flag indices (FLAG_V/C/N/Z), fs field slices.
//  One sub-module: datapath_alu (combinational, DATA_W param; a, b, fs -> result, {V,C,N,Z}).
//  Top holds register file, forward mux, EX/WB register, status register.
// TESTING (DATA_W=64, REG_COUNT=32, forwarding on unless stated)
//  1 k=24 -> R5 (PASS B, sel_b), k=39 -> R7, then R1<=R5+R7 issued next cycle -> data=63, data_valid=1.
//  2 R30<=R1^R5 back-to-back after 1 -> data=39; R17<=R30 SHL k=2 -> data=156; later read of R17 via PASS = 156.
//  3 R0<=R5-R7 (fs=01001, status_load) -> data=0xFFFF_FFFF_FFFF_FFF1, status {V,C,N,Z}=0010.
//  4 k=0x7FFF_FFFF_FFFF_FFFF + 1 via ADD, status_load -> data=0x8000_0000_0000_0000, status=1010; next op status_load=0 -> holds.
//  5 write 5 to R31, read R31 -> 0; assert reset mid-stream during write to R3 -> R3=0, data_valid=0, status=0.
//  6 REG_ALU_FORWARD_EN undefined: R5<=24 then R2<=R5 PASS next cycle -> data=0; with one bubble -> data=24.

Source files
------------

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared ALU opcodes, flag positions and fs field helpers
//  Used by datapath_alu and reg_alu_pipe_datapath.
package datapath_pkg;

    // fs[4:2] operation codes
    localparam logic [2:0] FS_AND   = 3'b000;
    localparam logic [2:0] FS_OR    = 3'b001;
    localparam logic [2:0] FS_ADD   = 3'b010;
    localparam logic [2:0] FS_XOR   = 3'b011;
    localparam logic [2:0] FS_SHL   = 3'b100;
    localparam logic [2:0] FS_SHR   = 3'b101;
    localparam logic [2:0] FS_ASR   = 3'b110;
    localparam logic [2:0] FS_PASSB = 3'b111;

    // bit positions inside the {V,C,N,Z} status word
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // fs field slices
    localparam int FS_OP_HI = 4;
    localparam int FS_OP_LO = 2;
    localparam int FS_INV_A = 1;
    localparam int FS_INV_B = 0;  // also the ADD carry-in

    function automatic logic [2:0] fs_op(input logic [4:0] fs);
        return fs[FS_OP_HI:FS_OP_LO];
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational ALU with {V,C,N,Z} flag generation
//  a, b    in   DATA_W  operands (before optional inversion)
//  fs      in   5       function select
//  result  out  DATA_W  ALU result
//  flags   out  4       {V,C,N,Z}; C and V only meaningful for ADD, else 0
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        fs,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] a_op;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   sum;
    logic [SH_W-1:0]   shamt;
    logic              carry;
    logic              ovf;

    // Inversions apply to every op; the B inversion doubles as carry-in so
    // that A + ~B + 1 gives subtraction.
    assign a_op  = fs[FS_INV_A] ? ~a : a;
    assign b_op  = fs[FS_INV_B] ? ~b : b;
    assign sum   = {1'b0, a_op} + {1'b0, b_op} + (DATA_W+1)'(fs[FS_INV_B]);
    assign shamt = b_op[SH_W-1:0];

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (fs_op(fs))
            FS_AND:   result = a_op & b_op;
            FS_OR:    result = a_op | b_op;
            FS_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                // overflow: like-signed operands yield a differently-signed sum
                ovf    = (a_op[DATA_W-1] == b_op[DATA_W-1]) &&
                         (sum[DATA_W-1] != a_op[DATA_W-1]);
            end
            FS_XOR:   result = a_op ^ b_op;
            FS_SHL:   result = a_op << shamt;
            FS_SHR:   result = a_op >> shamt;
            FS_ASR:   result = $signed(a_op) >>> shamt;
            FS_PASSB: result = b_op;
            default:  result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_V] = ovf;
        flags[FLAG_C] = carry;
        flags[FLAG_N] = result[DATA_W-1];
        flags[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/reg_alu_pipe_datapath.sv
// rtl/reg_alu_pipe_datapath.sv - two-stage (EX/WB) register file + ALU + status datapath
//  Optional feature macro: REG_ALU_FORWARD_EN (WB-to-EX result forwarding).
//  clock, reset (async, active-high)
//  issue_valid, da, sa, sb, fs, sel_b, reg_write, status_load, k : control word
//  data, data_valid : registered ALU result and its qualifier
//  status : registered {V,C,N,Z}
module reg_alu_pipe_datapath
    import datapath_pkg::*;
#(
    parameter  int DATA_W    = 64,
    parameter  int REG_COUNT = 32,
    localparam int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] da,
    input  logic [ADDR_W-1:0] sa,
    input  logic [ADDR_W-1:0] sb,
    input  logic [4:0]        fs,
    input  logic              sel_b,
    input  logic              reg_write,
    input  logic              status_load,
    input  logic [DATA_W-1:0] k,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic [3:0]        status
);

    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_COUNT - 1);

    logic [DATA_W-1:0] regs [REG_COUNT];

    // WB stage: the result itself lives in data, so only the write
    // qualifier and destination need to be staged.
    logic              wb_write;
    logic [ADDR_W-1:0] wb_da;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    always_comb begin
        op_a  = '0;
        reg_b = '0;
        if (sa == ZERO_REG) begin
            op_a = '0;
`ifdef REG_ALU_FORWARD_EN
        end else if (wb_write && (wb_da == sa)) begin
            op_a = data;
`endif
        end else begin
            op_a = regs[sa];
        end

        if (sb == ZERO_REG) begin
            reg_b = '0;
`ifdef REG_ALU_FORWARD_EN
        end else if (wb_write && (wb_da == sb)) begin
            reg_b = data;
`endif
        end else begin
            reg_b = regs[sb];
        end
    end

    assign op_b = sel_b ? k : reg_b;

    datapath_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .fs     (fs),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // EX/WB register and status
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            status     <= '0;
            wb_write   <= 1'b0;
            wb_da      <= '0;
        end else begin
            data_valid <= issue_valid;
            wb_write   <= issue_valid && reg_write;
            wb_da      <= da;
            if (issue_valid) begin
                data <= alu_result;
                if (status_load) begin
                    status <= alu_flags;
                end
            end
        end
    end

    // Register file write (WB stage); the zero register is never written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write && (wb_da != ZERO_REG)) begin
            regs[wb_da] <= data;
        end
    end

endmodule

// File: tb/tb_reg_alu_pipe_datapath.sv
// tb/tb_reg_alu_pipe_datapath.sv - self-checking bench for reg_alu_pipe_datapath
module tb_reg_alu_pipe_datapath;

`ifdef REG_ALU_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [4:0] F_PASS = 5'b11100;
    localparam logic [4:0] F_ADD  = 5'b01000;
    localparam logic [4:0] F_SUB  = 5'b01001;
    localparam logic [4:0] F_XOR  = 5'b01100;
    localparam logic [4:0] F_SHL  = 5'b10000;
    localparam logic [4:0] F_AND  = 5'b00000;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  da, sa, sb, fs;
    logic        sel_b, reg_write, status_load;
    logic [63:0] k;
    logic [63:0] data;
    logic        data_valid;
    logic [3:0]  status;

    int nvec  = 0;
    int nfail = 0;

    // reference model state
    logic [63:0] mreg [32];
    bit          pv;
    int          pda;
    logic [63:0] pval;
    logic [63:0] mdata;
    logic        mvalid;
    logic [3:0]  mstat;

    reg_alu_pipe_datapath dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .da          (da),
        .sa          (sa),
        .sb          (sb),
        .fs          (fs),
        .sel_b       (sel_b),
        .reg_write   (reg_write),
        .status_load (status_load),
        .k           (k),
        .data        (data),
        .data_valid  (data_valid),
        .status      (status)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_alu(input logic [63:0] a, input logic [63:0] b,
                                      input logic [4:0] f,
                                      output logic [63:0] r, output logic [3:0] fl);
        logic [63:0]        a2, b2;
        logic [64:0]        us;
        logic signed [65:0] sa2, sb2, sc, ss;
        int                 sh;
        logic               c, v;
        a2 = f[1] ? ~a : a;
        b2 = f[0] ? ~b : b;
        sh = int'(b2 % 64);
        c  = 1'b0;
        v  = 1'b0;
        case (f[4:2])
            3'd0: r = a2 & b2;
            3'd1: r = a2 | b2;
            3'd2: begin
                us  = 65'(a2) + 65'(b2) + 65'(f[0]);
                r   = us[63:0];
                c   = us[64];
                sa2 = $signed(a2);
                sb2 = $signed(b2);
                sc  = f[0];
                ss  = sa2 + sb2 + sc;
                v   = (ss > 66'sh7FFF_FFFF_FFFF_FFFF) || (ss < -66'sh8000_0000_0000_0000);
            end
            3'd3: r = a2 ^ b2;
            3'd4: r = a2 << sh;
            3'd5: r = a2 >> sh;
            3'd6: r = $signed(a2) >>> sh;
            default: r = b2;
        endcase
        fl = {v, c, r[63], r == 64'd0};
    endfunction

    function automatic logic [63:0] rd(input int r);
        if (r == 31) return 64'd0;
        if (FWD && pv && pda == r) return pval;
        return mreg[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
        pv     = 1'b0;
        pda    = 0;
        pval   = 64'd0;
        mdata  = 64'd0;
        mvalid = 1'b0;
        mstat  = 4'd0;
    endtask

    // Apply one control word for one clock and compare all outputs to the model.
    task automatic step(input bit iv, input int d, input int a, input int b,
                        input logic [4:0] f, input bit kb, input bit rw, input bit sl,
                        input logic [63:0] kk);
        logic [63:0] oa, ob, r;
        logic [3:0]  fl;
        issue_valid = iv;
        da          = 5'(d);
        sa          = 5'(a);
        sb          = 5'(b);
        fs          = f;
        sel_b       = kb;
        reg_write   = rw;
        status_load = sl;
        k           = kk;
        oa = rd(a);
        ob = kb ? kk : rd(b);
        if (pv && pda != 31) mreg[pda] = pval;
        if (iv) begin
            model_alu(oa, ob, f, r, fl);
            mdata  = r;
            mvalid = 1'b1;
            if (sl) mstat = fl;
            pv   = rw;
            pda  = d;
            pval = r;
        end else begin
            mvalid = 1'b0;
            pv     = 1'b0;
        end
        @(posedge clock);
        #1;
        check("data", data, mdata);
        check("data_valid", 64'(data_valid), 64'(mvalid));
        check("status", 64'(status), 64'(mstat));
    endtask

    task automatic bubble();
        step(0, 0, 0, 0, F_AND, 0, 0, 0, 64'd0);
    endtask

    initial begin
        issue_valid = 0; da = 0; sa = 0; sb = 0; fs = 0;
        sel_b = 0; reg_write = 0; status_load = 0; k = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_data", data, 64'd0);
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        reset = 1'b0;

        // 1: R5=24, R7=39, R1=R5+R7
        step(1, 5, 0, 0, F_PASS, 1, 1, 0, 64'd24);
        step(1, 7, 0, 0, F_PASS, 1, 1, 0, 64'd39);
        bubble();
        step(1, 1, 5, 7, F_ADD, 0, 1, 0, 64'd0);
        check("t1_data", data, 64'd63);
        check("t1_valid", 64'(data_valid), 64'd1);

        // 2: R30=R1^R5, R17=R30<<2, read R17
        bubble();
        step(1, 30, 1, 5, F_XOR, 0, 1, 0, 64'd0);
        check("t2_xor", data, 64'd39);
        bubble();
        step(1, 17, 30, 0, F_SHL, 1, 1, 0, 64'd2);
        check("t2_shl", data, 64'd156);
        bubble();
        step(1, 31, 0, 17, F_PASS, 0, 0, 0, 64'd0);
        check("t2_read", data, 64'd156);

        // 3: R0=R5-R7 with flags
        step(1, 0, 5, 7, F_SUB, 0, 1, 1, 64'd0);
        check("t3_data", data, 64'hFFFF_FFFF_FFFF_FFF1);
        check("t3_status", 64'(status), 64'b0010);

        // 4: signed overflow, then status hold
        step(1, 9, 0, 0, F_PASS, 1, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF);
        bubble();
        step(1, 10, 9, 0, F_ADD, 1, 1, 1, 64'd1);
        check("t4_data", data, 64'h8000_0000_0000_0000);
        check("t4_status", 64'(status), 64'b1010);
        step(1, 11, 5, 0, F_AND, 1, 1, 0, 64'd0);
        check("t4_hold", 64'(status), 64'b1010);

        // 5: zero register, then reset during an in-flight write to R3
        step(1, 31, 0, 0, F_PASS, 1, 1, 0, 64'd5);
        check("t5_w31", data, 64'd5);
        bubble();
        step(1, 2, 0, 31, F_PASS, 0, 1, 0, 64'd0);
        check("t5_r31", data, 64'd0);
        step(1, 3, 0, 0, F_PASS, 1, 1, 1, 64'd77);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("t5_rst_valid", 64'(data_valid), 64'd0);
        check("t5_rst_status", 64'(status), 64'd0);
        check("t5_rst_data", data, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1, 4, 0, 3, F_PASS, 0, 1, 0, 64'd0);
        check("t5_r3", data, 64'd0);

        // 6: back-to-back dependency, then with a bubble
        step(1, 8, 0, 0, F_PASS, 1, 1, 0, 64'd24);
        step(1, 2, 0, 8, F_PASS, 0, 1, 0, 64'd0);
        check("t6_b2b", data, FWD ? 64'd24 : 64'd0);
        step(1, 12, 0, 0, F_PASS, 1, 1, 0, 64'd24);
        bubble();
        check("t6_bubble_valid", 64'(data_valid), 64'd0);
        step(1, 2, 0, 12, F_PASS, 0, 1, 0, 64'd0);
        check("t6_gap", data, 64'd24);

        // randomized traffic with frequent hazards and zero-register use
        for (int i = 0; i < 400; i++) begin
            int d, a, b;
            d = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 7));
            a = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 7));
            b = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 7));
            step($urandom_range(0, 9) != 0, d, a, b, 5'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
